dds_pwm_dac: RTL and testbench
==============================

// Module: dds_pwm_dac
// PURPOSE
//  Downstream stage of the DDS core: consumes the wavetable samples (dds_out), scales them by an amplitude word
//  and drives a single-bit PWM DAC output. It holds one sample in a buffer, loads a new duty value once per PWM
//  period, and flags an underrun when the DDS side has not supplied a sample in time.
// PARAMETERS
//  WIDTH     8   sample/amplitude width; PWM period = 2**WIDTH clocks (set equal to the DDS MAX_AMP)
//  DEADTIME  2   dead-time clocks, complementary output only (see CONFIGURATION); 0 <= DEADTIME < 2**(WIDTH-1)
// PORTS
//  clk           in   1      system clock; one clock; reset is synchronous and active-high
//  res           in   1      synchronous active-high reset
//  enable        in   1      run PWM; low = counter held at 0, output low
//  sample_in     in   WIDTH  unsigned sample (DDS dds_out)
//  sample_valid  in   1      sample_in valid
//  sample_ready  out  1      holding buffer empty, sample can be accepted
//  amp           in   WIDTH  unsigned amplitude scale, sampled at accept
//  pwm_out       out  1      PWM output, registered
//  period_start  out  1      1-cycle pulse, counter == 0 while enabled
//  underrun      out  1      1-cycle pulse, period boundary reached with empty buffer
// BEHAVIOUR
//  - Reset: cnt=0, duty=0, buffer empty, pwm_out=0, period_start=0, underrun=0; sample_ready=1 from first post-reset cycle.
//  - Handshake: accept when sample_valid && sample_ready; sample_ready = !buf_full; valid may drop without accept.
//  - Accept: buf <= (sample_in * amp) >> WIDTH (2*WIDTH-bit product, truncate, no rounding); buf_full <= 1.
//  - Counter: cnt WIDTH bits, +1 per clk while enable, wraps 2**WIDTH-1 -> 0; enable low: cnt <= 0.
//  - Load cycle = enable && cnt == 2**WIDTH-1: buf_full ? (duty <= buf, buf_full <= 0) : (duty held, underrun pulse).
//  - Accept in load cycle with empty buffer: sample goes to buf, used at next boundary; underrun still pulses.
//  - Buffer full: sample_ready low, no overwrite; sample waits for next load cycle.
//  - pwm_out(t+1) = enable(t) && cnt(t) < duty(t); duty=0 -> never high; duty=2**WIDTH-1 -> high 2**WIDTH-1 of 2**WIDTH clocks.
//  - enable low: no loads, no underrun, no period_start; buffer still accepts; pwm_out low one clock later.
//  - Reset mid-period: all state cleared same edge; pending buffered sample discarded.
// CONFIGURATION
//  DDS_PWM_COMPLEMENTARY_EN defined: extra output pwm_out_n (1 bit, registered, reset 0);
//    pwm_out_n(t+1) = enable && cnt >= duty+DEADTIME && cnt < 2**WIDTH-DEADTIME (compare in WIDTH+1 bits);
//    pwm_out and pwm_out_n never high together.
//  Undefined: pwm_out_n port and logic absent; DEADTIME unused.
// STRUCTURE
//  Package dds_pkg: default sample width constant, PWM_PERIOD = 2**WIDTH, scale function (a*b)>>WIDTH.
//  Sub-module dds_pwm_counter: cnt, wrap, period_start and load-cycle strobe; top keeps buffer, scaler, compare.
// TESTING (WIDTH=8, DEADTIME=2)
//  1. res, enable=1, push 128 with amp=255 -> duty=127 next period; pwm_out high exactly 127 of 256 clocks.
//  2. No sample after first -> underrun pulses once per period at cnt=255; duty stays 127.
//  3. Push two samples in one period -> 2nd stalls (sample_ready=0) until load cycle, accepted the cycle after.
//  4. sample 255 amp 255 -> duty 254, 254 high clocks; sample 0 -> pwm_out constant 0, no glitch.
//  5. enable low at cnt=50 -> pwm_out 0 next clock, cnt=0; re-enable -> period_start on first cycle; res mid-period -> all outputs 0.
//  6. DDS_PWM_COMPLEMENTARY_EN, duty=100 -> pwm_out_n high for cnt 102..253; never overlaps pwm_out.

Source files
------------

// File: rtl/dds_pkg.sv
// ============================================================================
// Module      : dds_pkg
// Description : Shared constants and the amplitude scaling helper for the
//               DDS PWM DAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_pkg;

    localparam int DDS_WIDTH  = 8;
    localparam int PWM_PERIOD = 2 ** DDS_WIDTH;

    // Full-width product, truncated back down by the sample width (no rounding).
    function automatic logic [31:0] dds_scale(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        return 32'(prod >> w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dds_pwm_counter.sv
// ============================================================================
// Module      : dds_pwm_counter
// Description : Free-running PWM period counter with period-start and
//               load-cycle strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_pwm_counter
    import dds_pkg::*;
#(
    parameter int WIDTH = DDS_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    output logic [WIDTH-1:0] cnt,
    output logic             period_start,
    output logic             load_strobe
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Strobes are masked while reset is asserted so outputs read idle.
    assign cnt          = cnt_q;
    assign period_start = !res && enable && (cnt_q == '0);
    assign load_strobe  = !res && enable && (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/dds_pwm_dac.sv
// ============================================================================
// Module      : dds_pwm_dac
// Description : Scales DDS samples by an amplitude word and drives a 1-bit
//               PWM DAC; optional complementary output via the macro
//               DDS_PWM_COMPLEMENTARY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_pwm_dac
    import dds_pkg::*;
#(
    parameter int WIDTH    = DDS_WIDTH,
    parameter int DEADTIME = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [WIDTH-1:0] amp,
    output logic             pwm_out,
`ifdef DDS_PWM_COMPLEMENTARY_EN
    output logic             pwm_out_n,
`endif
    output logic             period_start,
    output logic             underrun
);

    localparam int PERIOD = 2 ** WIDTH;

    if (DEADTIME < 0 || DEADTIME >= (PERIOD / 2)) begin : g_deadtime_check
        $error("dds_pwm_dac: DEADTIME out of range");
    end

    logic [WIDTH-1:0] cnt;
    logic             load_strobe;

    dds_pwm_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk          (clk),
        .res          (res),
        .enable       (enable),
        .cnt          (cnt),
        .period_start (period_start),
        .load_strobe  (load_strobe)
    );

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             accept;

    always_comb begin
        accept      = sample_valid && !hold_full_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        duty_d      = duty_q;
        pwm_d       = enable && (cnt < duty_q);

        if (load_strobe && hold_full_q) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
        end

        // Accept only happens with an empty buffer, so it never collides with a load.
        if (accept) begin
            hold_d      = WIDTH'(dds_scale(32'(sample_in), 32'(amp), WIDTH));
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign pwm_out      = pwm_q;
    assign underrun     = load_strobe && !hold_full_q;

`ifdef DDS_PWM_COMPLEMENTARY_EN
    localparam logic [WIDTH:0] DEAD_W  = (WIDTH+1)'(DEADTIME);
    localparam logic [WIDTH:0] DEAD_HI = (WIDTH+1)'(PERIOD - DEADTIME);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] dead_lo;
    logic           pwm_n_q, pwm_n_d;

    // One extra bit keeps duty+DEADTIME from wrapping near full scale.
    always_comb begin
        cnt_ext = {1'b0, cnt};
        dead_lo = {1'b0, duty_q} + DEAD_W;
        pwm_n_d = enable && (cnt_ext >= dead_lo) && (cnt_ext < DEAD_HI);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pwm_n_q <= 1'b0;
        end else begin
            pwm_n_q <= pwm_n_d;
        end
    end

    assign pwm_out_n = pwm_n_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_dds_pwm_dac.sv
// ============================================================================
// Module      : tb_dds_pwm_dac
// Description : Self-checking bench for dds_pwm_dac (WIDTH=8, DEADTIME=2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dds_pwm_dac;

    localparam int WIDTH    = 8;
    localparam int DEADTIME = 2;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic [WIDTH-1:0] amp = '0;
    logic             pwm_out;
    logic             period_start;
    logic             underrun;
`ifdef DDS_PWM_COMPLEMENTARY_EN
    logic             pwm_out_n;
`endif

    dds_pwm_dac #(
        .WIDTH    (WIDTH),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk          (clk),
        .res          (res),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .amp          (amp),
        .pwm_out      (pwm_out),
`ifdef DDS_PWM_COMPLEMENTARY_EN
        .pwm_out_n    (pwm_out_n),
`endif
        .period_start (period_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] sample;
        logic [7:0] amp;
        int         exp_duty;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res          = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        tick();
        check("rst_pwm_out", 32'(pwm_out), 0);
        check("rst_period_start", 32'(period_start), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_sample_ready", 32'(sample_ready), 1);
        res = 1'b0;
    endtask

    // Runs n cycles and tallies what the outputs did.
    task automatic run(input int n, output int hi, output int hi_n, output int ovl,
                       output int und, output int ps);
        hi = 0; hi_n = 0; ovl = 0; und = 0; ps = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            hi  += int'(pwm_out);
            und += int'(underrun);
            ps  += int'(period_start);
`ifdef DDS_PWM_COMPLEMENTARY_EN
            hi_n += int'(pwm_out_n);
            ovl  += int'(pwm_out && pwm_out_n);
`endif
        end
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] a);
        sample_in    = s;
        amp          = a;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        int hi, hi_n, ovl, und, ps;
        int exp_n;

        vecs[0] = '{8'd128, 8'd255, 127};
        vecs[1] = '{8'd255, 8'd255, 254};
        vecs[2] = '{8'd0,   8'd255, 0};
        vecs[3] = '{8'd200, 8'd128, 100};
        vecs[4] = '{8'd1,   8'd1,   0};
        vecs[5] = '{8'd255, 8'd1,   0};
        vecs[6] = '{8'd100, 8'd200, 78};
        vecs[7] = '{8'd64,  8'd64,  16};

        // Scaling and duty vectors: one sample, then two empty periods.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            push(vecs[v].sample, vecs[v].amp);
            check("vec_ready_after_push", 32'(sample_ready), 0);
            run(255, hi, hi_n, ovl, und, ps);
            check("vec_p1_high", hi, 0);
            check("vec_p1_underrun", und, 0);
            check("vec_p1_pstart", ps, 1);
            run(256, hi, hi_n, ovl, und, ps);
            check("vec_p2_high", hi, vecs[v].exp_duty);
            check("vec_p2_underrun", und, 1);
`ifdef DDS_PWM_COMPLEMENTARY_EN
            exp_n = (vecs[v].exp_duty + DEADTIME <= 253) ? (254 - DEADTIME - vecs[v].exp_duty) : 0;
            check("vec_p2_high_n", hi_n, exp_n);
            check("vec_p2_overlap", ovl, 0);
`else
            exp_n = 0;
`endif
            run(256, hi, hi_n, ovl, und, ps);
            check("vec_p3_high_held", hi, vecs[v].exp_duty);
            check("vec_p3_underrun", und, 1);
            check("vec_p3_pstart", ps, 1);
        end

        // Second sample stalls until the load cycle frees the buffer.
        do_reset();
        push(8'd128, 8'd255);
        run(8, hi, hi_n, ovl, und, ps);
        sample_in    = 8'd255;
        amp          = 8'd255;
        sample_valid = 1'b1;
        tick();
        check("stall_ready_c10", 32'(sample_ready), 0);
        run(245, hi, hi_n, ovl, und, ps);
        check("stall_ready_load", 32'(sample_ready), 0);
        check("stall_no_underrun_load", 32'(underrun), 0);
        tick();
        check("stall_ready_after_load", 32'(sample_ready), 1);
        tick();
        check("stall_accepted", 32'(sample_ready), 0);
        sample_valid = 1'b0;
        run(255, hi, hi_n, ovl, und, ps);
        check("stall_p2_underrun", und, 0);
        run(256, hi, hi_n, ovl, und, ps);
        check("stall_p3_high", hi, 254);
        check("stall_p3_underrun", und, 1);

        // Accept during an underrunning load cycle.
        do_reset();
        run(254, hi, hi_n, ovl, und, ps);
        check("ld_pre_underrun", und, 0);
        tick();
        check("ld_underrun_pulse", 32'(underrun), 1);
        check("ld_ready", 32'(sample_ready), 1);
        sample_in    = 8'd200;
        amp          = 8'd128;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("ld_ready_full", 32'(sample_ready), 0);
        check("ld_underrun_single", 32'(underrun), 0);
        run(256, hi, hi_n, ovl, und, ps);
        check("ld_p2_high", hi, 0);
        check("ld_p2_underrun", und, 0);
        run(256, hi, hi_n, ovl, und, ps);
        check("ld_p3_high", hi, 100);

        // Enable drop mid-period, re-enable, then reset mid-period.
        do_reset();
        push(8'd128, 8'd255);
        run(305, hi, hi_n, ovl, und, ps);
        check("en_pwm_before_drop", 32'(pwm_out), 1);
        enable = 1'b0;
        tick();
        check("en_pwm_low", 32'(pwm_out), 0);
        check("en_pstart_low", 32'(period_start), 0);
        check("en_ready_idle", 32'(sample_ready), 1);
        push(8'd64, 8'd64);
        check("en_accept_disabled", 32'(sample_ready), 0);
        run(20, hi, hi_n, ovl, und, ps);
        check("en_off_high", hi, 0);
        check("en_off_underrun", und, 0);
        check("en_off_pstart", ps, 0);
        enable = 1'b1;
        #1;
        check("en_reenable_pstart", 32'(period_start), 1);
        run(50, hi, hi_n, ovl, und, ps);
        check("en_pwm_resumed", 32'(pwm_out), 1);
        res = 1'b1;
        tick();
        check("mid_rst_pwm", 32'(pwm_out), 0);
        check("mid_rst_ready", 32'(sample_ready), 1);
        check("mid_rst_pstart", 32'(period_start), 0);
        check("mid_rst_underrun", 32'(underrun), 0);
        res = 1'b0;
        run(600, hi, hi_n, ovl, und, ps);
        check("mid_rst_discard_high", hi, 0);
        check("mid_rst_underruns", und, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
